// File: rtl/ssd_pkg.sv
// Shared segment encodings and BCD sizing for the seven-segment display driver.
// Segment bytes are active-low {a,b,c,d,e,f,g,dp} with the decimal point off.
package ssd_pkg;

  localparam int BCD_DIGIT_W      = 4;
  localparam int BCD_EXTRA_DIGITS = 1;

  localparam logic [7:0] SEG_0     = 8'b0000_0011;
  localparam logic [7:0] SEG_1     = 8'b1001_1111;
  localparam logic [7:0] SEG_2     = 8'b0010_0101;
  localparam logic [7:0] SEG_3     = 8'b0000_1101;
  localparam logic [7:0] SEG_4     = 8'b1001_1001;
  localparam logic [7:0] SEG_5     = 8'b0100_1001;
  localparam logic [7:0] SEG_6     = 8'b0100_0001;
  localparam logic [7:0] SEG_7     = 8'b0001_1111;
  localparam logic [7:0] SEG_8     = 8'b0000_0001;
  localparam logic [7:0] SEG_9     = 8'b0000_1001;
  localparam logic [7:0] SEG_BLANK = 8'b1111_1111;
  localparam logic [7:0] SEG_DASH  = 8'b1111_1101;

  // One spare digit above the displayed ones catches out-of-range values.
  function automatic int bcd_width(input int num_digits);
    return (num_digits + BCD_EXTRA_DIGITS) * BCD_DIGIT_W;
  endfunction

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_converter.sv
// Sequential double-dabble: one shift/add-3 step per clock, then one Done cycle
// while Busy is still high. Spill flags any bit carried out of the top BCD digit.
module bcd_converter
  import ssd_pkg::*;
#(
  parameter int VALUE_W    = 8,
  parameter int NUM_DIGITS = 4
) (
  input  logic                               Clk,
  input  logic                               Reset,
  input  logic                               Start,
  input  logic [VALUE_W-1:0]                 Value,
  output logic                               Busy,
  output logic                               Done,
  output logic [bcd_width(NUM_DIGITS)-1:0]   Bcd,
  output logic                               Spill
);

  localparam int BW    = bcd_width(NUM_DIGITS);
  localparam int CNT_W = $clog2(VALUE_W + 1);

  logic [VALUE_W-1:0] bin_q;
  logic [BW-1:0]      bcd_q;
  logic [BW-1:0]      bcd_adj;
  logic [CNT_W-1:0]   cnt_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < NUM_DIGITS + BCD_EXTRA_DIGITS; d++) begin
      if (bcd_q[d*4 +: 4] >= 4'd5) bcd_adj[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Busy  <= 1'b0;
      cnt_q <= '0;
    end else if (Start) begin
      Busy  <= 1'b1;
      cnt_q <= CNT_W'(VALUE_W);
    end else if (Busy) begin
      if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
      else             Busy  <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Start) begin
      bin_q <= Value;
      bcd_q <= '0;
      Spill <= 1'b0;
    end else if (Busy && cnt_q != '0) begin
      bcd_q <= {bcd_adj[BW-2:0], bin_q[VALUE_W-1]};
      bin_q <= bin_q << 1;
      Spill <= Spill | bcd_adj[BW-1];
    end
  end

  assign Done = Busy && (cnt_q == '0);
  assign Bcd  = bcd_q;

endmodule

// File: rtl/ssd_multiplex_display.sv
// N-digit multiplexed seven-segment driver: captures a binary value, converts it to
// BCD in the background and scans the anodes with blanking, decimal points and overflow dashes.
module ssd_multiplex_display
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int VALUE_W       = 8,
  parameter int REFRESH_DIV   = 18,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [VALUE_W-1:0]    Value,
  input  logic                  Load,
  input  logic [NUM_DIGITS-1:0] Dp_Mask,
  output logic [NUM_DIGITS-1:0] An,
  output logic [7:0]            Cathodes,
  output logic                  Busy,
  output logic                  Overflow
);

  localparam int BW     = bcd_width(NUM_DIGITS);
  localparam int DISP_W = NUM_DIGITS * BCD_DIGIT_W;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                   conv_start;
  logic                   conv_busy;
  logic                   conv_done;
  logic                   conv_spill;
  logic [VALUE_W-1:0]     conv_value;
  logic [BW-1:0]          conv_bcd;
  logic                   pend_vld;
  logic [VALUE_W-1:0]     pend_val;
  logic [DISP_W-1:0]      disp_q;
  logic [REFRESH_DIV-1:0] ref_cnt;
  logic [IDX_W-1:0]       idx_q;
  logic [7:0]             seg_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]  an_sel_p0;
  logic [7:0]             seg_p0;
  logic                   dp_p0;

  // A Load arriving on the commit cycle wins over an older pending value.
  always_comb begin
    conv_start = 1'b0;
    conv_value = Value;
    if (!conv_busy) begin
      conv_start = Load;
    end else if (conv_done) begin
      conv_start = Load || pend_vld;
      if (!Load) conv_value = pend_val;
    end
  end

  bcd_converter #(
    .VALUE_W    (VALUE_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (conv_start),
    .Value (conv_value),
    .Busy  (conv_busy),
    .Done  (conv_done),
    .Bcd   (conv_bcd),
    .Spill (conv_spill)
  );

  assign Busy = conv_busy;

  always_ff @(posedge Clk) begin
    if (Reset)                             pend_vld <= 1'b0;
    else if (conv_done)                    pend_vld <= 1'b0;
    else if (Load && conv_busy)            pend_vld <= 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Load && conv_busy && !conv_done) pend_val <= Value;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      disp_q   <= '0;
      Overflow <= 1'b0;
    end else if (conv_done) begin
      disp_q   <= conv_bcd[DISP_W-1:0];
      Overflow <= (conv_bcd[BW-1 -: 4] != 4'd0) || conv_spill;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ref_cnt <= '0;
      idx_q   <= '0;
    end else begin
      ref_cnt <= ref_cnt + REFRESH_DIV'(1);
      if (&ref_cnt) idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Walk from the top digit down so 'lead' means "this and every higher digit is zero".
  always_comb begin : blank_chain
    logic       lead;
    logic [3:0] digit;
    seg_digit = '{default: SEG_BLANK};
    lead      = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      digit = disp_q[k*4 +: 4];
      lead  = lead && (digit == 4'd0);
      if (Overflow)                                 seg_digit[k] = SEG_DASH;
      else if (BLANK_LEADING != 0 && k > 0 && lead) seg_digit[k] = SEG_BLANK;
      else                                          seg_digit[k] = bcd_to_seg(digit);
    end
  end

  always_comb begin
    an_sel_p0 = '0;
    seg_p0    = SEG_BLANK;
    dp_p0     = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        an_sel_p0[k] = 1'b1;
        seg_p0       = seg_digit[k];
        dp_p0        = ~Dp_Mask[k];
      end
    end
  end

  // p0 -> output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      An       <= '1;
      Cathodes <= SEG_BLANK;
    end else begin
      An       <= ~an_sel_p0;
      Cathodes <= seg_p0 & {7'b111_1111, dp_p0};
    end
  end

endmodule

// File: tb/tb_ssd_multiplex_display.sv
// Scoreboard bench for ssd_multiplex_display: an 8-bit and a 16-bit instance share
// clock and reset; expected displays are queued at Load and checked after each commit.
module tb_ssd_multiplex_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  value8;
  logic        load8;
  logic [15:0] value16;
  logic        load16;
  logic [3:0]  dp_mask;
  logic [3:0]  an8, an16;
  logic [7:0]  cath8, cath16;
  logic        busy8, busy16, ovf8, ovf16;
  bit          sel;
  logic [3:0]  an_obs;
  logic [7:0]  cath_obs;
  logic        busy_obs, ovf_obs;

  assign an_obs   = sel ? an16   : an8;
  assign cath_obs = sel ? cath16 : cath8;
  assign busy_obs = sel ? busy16 : busy8;
  assign ovf_obs  = sel ? ovf16  : ovf8;

  always #5 clk = ~clk;

  ssd_multiplex_display #(
    .NUM_DIGITS(4), .VALUE_W(8), .REFRESH_DIV(3), .BLANK_LEADING(1)
  ) dut (
    .Clk(clk), .Reset(reset), .Value(value8), .Load(load8), .Dp_Mask(dp_mask),
    .An(an8), .Cathodes(cath8), .Busy(busy8), .Overflow(ovf8)
  );

  ssd_multiplex_display #(
    .NUM_DIGITS(4), .VALUE_W(16), .REFRESH_DIV(3), .BLANK_LEADING(1)
  ) dut16 (
    .Clk(clk), .Reset(reset), .Value(value16), .Load(load16), .Dp_Mask(dp_mask),
    .An(an16), .Cathodes(cath16), .Busy(busy16), .Overflow(ovf16)
  );

  typedef struct {
    int unsigned val;
    logic [3:0]  dp;
    bit          wide;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic [7:0] seg_tab [10] = '{8'b0000_0011, 8'b1001_1111, 8'b0010_0101, 8'b0000_1101,
                               8'b1001_1001, 8'b0100_1001, 8'b0100_0001, 8'b0001_1111,
                               8'b0000_0001, 8'b0000_1001};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_cath(input int unsigned v, input int k, input logic [3:0] dp);
    logic [7:0]  c;
    int unsigned p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (v >= 10000)          c = 8'b1111_1101;
    else if (k > 0 && v < p) c = 8'hFF;
    else                     c = seg_tab[(v / p) % 10];
    if (dp[k]) c[0] = 1'b0;
    return c;
  endfunction

  function automatic int an_index(input logic [3:0] an);
    case (an)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic scan_check(input string tag, input exp_t e);
    logic [7:0] got [4];
    bit         seen [4];
    int         viol;
    int         k;
    viol = 0;
    for (int i = 0; i < 4; i++) begin
      seen[i] = 1'b0;
      got[i]  = 8'h00;
    end
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      k = an_index(an_obs);
      if (k < 0) viol++;
      else begin
        seen[k] = 1'b1;
        got[k]  = cath_obs;
      end
    end
    chk({tag, "_onehot_viol"}, viol, 0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_d%0d", tag, i), seen[i] ? {24'd0, got[i]} : 32'hDEAD,
          {24'd0, model_cath(e.val, i, e.dp)});
  endtask

  task automatic check_next(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e   = sb.pop_front();
    sel = e.wide;
    @(negedge clk);
    chk({tag, "_ovf"}, ovf_obs, (e.val >= 10000) ? 1 : 0);
    scan_check(tag, e);
  endtask

  task automatic do_load(input string tag, input bit wide, input int unsigned v, input logic [3:0] dp);
    int cnt;
    cnt     = 0;
    sel     = wide;
    dp_mask = dp;
    sb.push_back('{val: v, dp: dp, wide: wide});
    @(posedge clk); #1;
    if (wide) begin load16 = 1'b1; value16 = 16'(v); end
    else      begin load8  = 1'b1; value8  = 8'(v);  end
    @(posedge clk); #1;
    load8  = 1'b0;
    load16 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy_obs) cnt++;
      else break;
    end
    chk({tag, "_busy_len"}, cnt, wide ? 17 : 9);
  endtask

  task automatic check_an_seq();
    bit         found;
    logic [3:0] prev;
    logic [3:0] e4;
    found = 1'b0;
    prev  = an8;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an8 == 4'b1110 && prev != 4'b1110) begin
        found = 1'b1;
        break;
      end
      prev = an8;
    end
    chk("an_sync", found, 1);
    if (found) begin
      for (int j = 1; j < 32; j++) begin
        @(negedge clk);
        e4 = ~(4'b0001 << (j / 8));
        chk($sformatf("an_seq%0d", j), an8, e4);
      end
    end
  endtask

  initial begin
    int  cnt;
    bit  done;
    int  k;
    exp_t e;

    reset   = 1'b1;
    load8   = 1'b0;
    load16  = 1'b0;
    value8  = '0;
    value16 = '0;
    dp_mask = '0;
    sel     = 1'b0;

    // reset held for two clocks
    @(negedge clk);
    chk("rst_an", an8, 4'hF);
    chk("rst_cath", cath8, 8'hFF);
    @(negedge clk);
    chk("rst_an2", an8, 4'hF);
    chk("rst_cath2", cath8, 8'hFF);
    chk("rst_busy", busy8, 0);
    chk("rst_ovf", ovf8, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_an", an8, 4'b1110);
    chk("post_rst_cath", cath8, 8'b0000_0011);
    sb.push_back('{val: 0, dp: 4'b0000, wide: 1'b0});
    check_next("zero");

    do_load("v7", 1'b0, 7, 4'b0000);
    check_next("v7");
    check_an_seq();

    do_load("v205", 1'b0, 205, 4'b0100);
    check_next("v205");

    do_load("w12345", 1'b1, 12345, 4'b0000);
    check_next("w12345");
    do_load("w42", 1'b1, 42, 4'b0000);
    check_next("w42");

    // Load 10, then 99 and 55 while busy; 55 supersedes 99
    sel     = 1'b0;
    dp_mask = 4'b0000;
    sb.push_back('{val: 10, dp: 4'b0000, wide: 1'b0});
    @(posedge clk); #1;
    load8  = 1'b1;
    value8 = 8'd10;
    @(posedge clk); #1;
    load8  = 1'b0;
    cnt    = 0;
    done   = 1'b0;
    for (int c = 1; c < 60 && !done; c++) begin
      if (c == 3) begin
        load8  = 1'b1;
        value8 = 8'd99;
        sb.push_back('{val: 99, dp: 4'b0000, wide: 1'b0});
      end else if (c == 5) begin
        load8  = 1'b1;
        value8 = 8'd55;
        void'(sb.pop_back());
        sb.push_back('{val: 55, dp: 4'b0000, wide: 1'b0});
      end else begin
        load8 = 1'b0;
      end
      @(negedge clk);
      if (busy8) cnt++;
      else done = 1'b1;
      if (c >= 12 && c <= 18) begin
        k = an_index(an8);
        if (k < 0) chk($sformatf("pend_first_an_c%0d", c), 1, 0);
        else chk($sformatf("pend_first_c%0d", c), cath8, model_cath(sb[0].val, k, 4'b0000));
      end
      @(posedge clk); #1;
    end
    load8 = 1'b0;
    chk("pend_busy_len", cnt, 18);
    e = sb.pop_front();
    chk("pend_first_val", e.val, 10);
    check_next("pend55");

    // reset during busy cycle 4 of Load 200
    sel = 1'b0;
    @(posedge clk); #1;
    load8  = 1'b1;
    value8 = 8'd200;
    @(posedge clk); #1;
    load8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy8, 0);
    chk("midrst_ovf", ovf8, 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy8) cnt++;
    end
    chk("midrst_no_restart", cnt, 0);
    sb.push_back('{val: 0, dp: 4'b0000, wide: 1'b0});
    check_next("midrst0");

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
